// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared widths, source-select codes and state encoding for the write-back stage
package writeback_stage_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_MEM_WAIT_MAX = 15;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: memory-stage to write-back handshake (in_valid/in_ready plus regwr, wraddr, src, alu, link payload)
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic in_valid;
  logic in_ready;
  logic in_regwr;
  logic [ADDR_W-1:0] in_wraddr;
  logic [1:0] in_src;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_link;
  modport master(output in_valid, in_regwr, in_wraddr, in_src, in_alu, in_link, input in_ready);
  modport slave(input in_valid, in_regwr, in_wraddr, in_src, in_alu, in_link, output in_ready);
endinterface

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: load-wait counter (clock, reset, clear, enable in; tc out, high on the last permitted wait cycle)
module wb_timeout_counter #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end
  assign tc = cnt == LAST;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: retires one instruction per transfer on up, writes regfile via regWren/wraddr/wrdata, taps fwd_*, flags load timeouts on mem_err
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MEM_WAIT_MAX = DEF_MEM_WAIT_MAX
) (
  input  logic clock,
  input  logic reset,
  writeback_stage_if.slave up,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic mem_ready,
  output logic regWren,
  output logic [ADDR_W-1:0] wraddr,
  output logic [DATA_W-1:0] wrdata,
  output logic fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic mem_err
);
  state_t state;
  logic p_regwr;
  logic [ADDR_W-1:0] p_addr;
  logic accept, is_mem, tc;
  logic [DATA_W-1:0] sel;
  assign up.in_ready = state != WAIT_MEM;
  assign accept = up.in_valid && up.in_ready;
  assign is_mem = up.in_src == SRC_MEM;
  assign sel = up.in_src == SRC_LINK ? up.in_link : up.in_alu;
  assign fwd_valid = state == COMMIT && p_regwr;
  assign fwd_addr = wraddr;
  assign fwd_data = wrdata;
  wb_timeout_counter #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_tmo (
    .clock(clock),
    .reset(reset),
    .clear(accept && is_mem),
    .enable(state == WAIT_MEM && !mem_ready),
    .tc(tc)
  );
  // wraddr/wrdata change only when a real write lands, so they hold across idle and non-writing commits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      regWren <= 1'b0;
      wraddr <= '0;
      wrdata <= '0;
      mem_err <= 1'b0;
      p_regwr <= 1'b0;
      p_addr <= '0;
    end else begin
      regWren <= 1'b0;
      if (accept) begin
        p_regwr <= up.in_regwr;
        p_addr <= up.in_wraddr;
        if (is_mem) state <= WAIT_MEM;
        else begin
          state <= COMMIT;
          regWren <= up.in_regwr;
          if (up.in_regwr) begin
            wraddr <= up.in_wraddr;
            wrdata <= sel;
          end
        end
      end else if (state == WAIT_MEM) begin
        if (mem_ready) begin
          state <= COMMIT;
          regWren <= p_regwr;
          if (p_regwr) begin
            wraddr <= p_addr;
            wrdata <= mem_rdata;
          end
        end else if (tc) begin
          state <= IDLE;
          mem_err <= 1'b1;
        end
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage
module tb_writeback_stage;
  import writeback_stage_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic [15:0] mem_rdata;
  logic mem_ready;
  logic regWren, fwd_valid, mem_err;
  logic [2:0] wraddr, fwd_addr;
  logic [15:0] wrdata, fwd_data;
  int passed = 0, total = 0;
  writeback_stage_if bus ();
  writeback_stage dut (
    .clock(clock), .reset(reset), .up(bus),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .regWren(regWren), .wraddr(wraddr), .wrdata(wrdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .mem_err(mem_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v, input logic rw, input logic [2:0] a, input logic [1:0] s, input logic [15:0] alu, input logic [15:0] link);
    bus.in_valid = v;
    bus.in_regwr = rw;
    bus.in_wraddr = a;
    bus.in_src = s;
    bus.in_alu = alu;
    bus.in_link = link;
  endtask
  initial begin
    reset = 1'b1;
    mem_rdata = '0;
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst_regWren", regWren, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    drive(1, 1, 3, SRC_ALU, 16'h1234, 16'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("alu_regWren", regWren, 1);
    chk("alu_wraddr", wraddr, 3);
    chk("alu_wrdata", wrdata, 16'h1234);
    chk("alu_fwd_valid", fwd_valid, 1);
    chk("alu_fwd_addr", fwd_addr, 3);
    chk("alu_fwd_data", fwd_data, 16'h1234);
    cyc();
    chk("alu_pulse_end", regWren, 0);
    chk("alu_hold_addr", wraddr, 3);
    chk("alu_fwd_off", fwd_valid, 0);
    drive(1, 1, 5, SRC_MEM, 16'h0, 16'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", bus.in_ready, 0);
      chk("ld_no_wr", regWren, 0);
      chk("ld_no_fwd", fwd_valid, 0);
      cyc();
    end
    chk("ld_stall4", bus.in_ready, 0);
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    cyc();
    mem_ready = 1'b0;
    chk("ld_regWren", regWren, 1);
    chk("ld_wraddr", wraddr, 5);
    chk("ld_wrdata", wrdata, 16'hBEEF);
    chk("ld_mem_err", mem_err, 0);
    chk("ld_ready", bus.in_ready, 1);
    cyc();
    chk("ld_pulse_end", regWren, 0);
    drive(1, 1, 6, SRC_MEM, 16'h0, 16'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc();
    chk("tmo_still_wait", bus.in_ready, 0);
    chk("tmo_err_early", mem_err, 0);
    cyc();
    chk("tmo_mem_err", mem_err, 1);
    chk("tmo_no_wr", regWren, 0);
    chk("tmo_idle", bus.in_ready, 1);
    chk("tmo_addr_held", wraddr, 5);
    cyc();
    chk("tmo_err_sticky", mem_err, 1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    chk("rst_clears_err", mem_err, 0);
    drive(1, 1, 4, SRC_MEM, 16'h0, 16'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc();
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    cyc();
    mem_ready = 1'b0;
    chk("lim_regWren", regWren, 1);
    chk("lim_wraddr", wraddr, 4);
    chk("lim_wrdata", wrdata, 16'h5A5A);
    chk("lim_mem_err", mem_err, 0);
    drive(1, 1, 1, SRC_ALU, 16'h0001, 16'h0);
    cyc();
    chk("b2b1_regWren", regWren, 1);
    chk("b2b1_wraddr", wraddr, 1);
    chk("b2b1_wrdata", wrdata, 16'h0001);
    chk("b2b1_ready", bus.in_ready, 1);
    drive(1, 1, 2, SRC_ALU, 16'h0002, 16'h0);
    cyc();
    chk("b2b2_regWren", regWren, 1);
    chk("b2b2_wraddr", wraddr, 2);
    chk("b2b2_wrdata", wrdata, 16'h0002);
    chk("b2b2_ready", bus.in_ready, 1);
    drive(1, 1, 7, SRC_ALU, 16'hFFFF, 16'h0);
    cyc();
    chk("b2b3_regWren", regWren, 1);
    chk("b2b3_wraddr", wraddr, 7);
    chk("b2b3_wrdata", wrdata, 16'hFFFF);
    chk("b2b3_fwd_valid", fwd_valid, 1);
    drive(1, 1, 7, SRC_LINK, 16'h9999, 16'h0042);
    cyc();
    chk("link_regWren", regWren, 1);
    chk("link_wraddr", wraddr, 7);
    chk("link_wrdata", wrdata, 16'h0042);
    drive(1, 0, 2, SRC_ALU, 16'h1111, 16'h0);
    cyc();
    chk("nowr_regWren", regWren, 0);
    chk("nowr_fwd_valid", fwd_valid, 0);
    chk("nowr_wraddr", wraddr, 7);
    chk("nowr_wrdata", wrdata, 16'h0042);
    drive(1, 1, 6, 2'd3, 16'h3333, 16'h4444);
    cyc();
    chk("src3_regWren", regWren, 1);
    chk("src3_wrdata", wrdata, 16'h3333);
    drive(1, 1, 0, SRC_ALU, 16'h00AA, 16'h0);
    cyc();
    chk("r0_regWren", regWren, 1);
    chk("r0_wraddr", wraddr, 0);
    chk("r0_wrdata", wrdata, 16'h00AA);
    drive(1, 1, 3, SRC_MEM, 16'h0, 16'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("arst_pre_wait", bus.in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_regWren", regWren, 0);
    chk("arst_wraddr", wraddr, 0);
    chk("arst_wrdata", wrdata, 0);
    chk("arst_fwd_valid", fwd_valid, 0);
    chk("arst_mem_err", mem_err, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h7777;
    cyc();
    mem_ready = 1'b0;
    chk("arst_late_regWren", regWren, 0);
    chk("arst_late_wrdata", wrdata, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage of the 16-bit core; sits directly upstream of the register file and drives its regWren/wraddr/wrdata write port.
- Accepts one retiring instruction at a time from the memory stage over a valid/ready handshake.
- Selects the write-back source: ALU result, load data from data memory, or link value (PC+1).
- Waits on variable-latency load data with a bounded timeout.
- Exposes a forwarding tap so the operand-read stage can bypass the pending write.

Parameters:
DATA_W, 16, data path width (register width)
ADDR_W, 3, register address width (8 registers)
MEM_WAIT_MAX, 15, maximum cycles spent waiting for mem_ready before abort

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  upstream presents a retiring instruction
in_ready  output  1  stage can accept; transfer when in_valid && in_ready at rising edge
in_regwr  input  1  instruction writes a register
in_wraddr  input  ADDR_W  destination register
in_src  input  2  source select: 0=ALU, 1=MEM, 2=LINK, 3=reserved (treated as ALU)
in_alu  input  DATA_W  ALU result
in_link  input  DATA_W  PC+1 for link instructions
mem_rdata  input  DATA_W  load data, valid when mem_ready=1
mem_ready  input  1  load data valid strobe
regWren  output  1  register-file write enable, one-cycle pulse
wraddr  output  ADDR_W  register-file write address
wrdata  output  DATA_W  register-file write data
fwd_valid  output  1  fwd_addr/fwd_data hold a committed-pending result
fwd_addr  output  ADDR_W  pending destination
fwd_data  output  DATA_W  pending value
mem_err  output  1  sticky: a load timed out; cleared only by reset

Behaviour:
- Register file writes on the falling clock edge, so all write-port outputs are registered on the rising edge and stable for the whole cycle.
- Reset (asynchronous): state=IDLE, regWren=0, wraddr=0, wrdata=0, mem_err=0, wait counter=0, fwd_valid=0. Reset mid-operation drops the in-flight instruction; no write occurs.
- States:
  - IDLE: in_ready=1. On transfer:
    - in_src!=MEM -> latch address, regwr flag and selected data; go COMMIT.
    - in_src==MEM -> latch address and regwr flag; clear counter; go WAIT_MEM.
  - WAIT_MEM: in_ready=0. If mem_ready=1, latch mem_rdata and go COMMIT. Else increment counter. When the counter reaches MEM_WAIT_MAX with mem_ready=0: set mem_err, drop the write, go IDLE. If mem_ready=1 in the same cycle the counter reaches the limit, the data wins.
  - COMMIT: regWren=latched regwr for exactly this cycle; wraddr/wrdata = latched values. in_ready=1, so back-to-back transfer is allowed; the next state follows the IDLE rules for the new instruction, otherwise go IDLE.
- regWren is 0 in every state except COMMIT, and 0 in COMMIT when regwr=0. wraddr/wrdata hold their last values when regWren=0.
- Latency: non-load accepted at edge N -> regWren high during cycle N..N+1. Load: mem_ready sampled at edge M -> regWren high during cycle M..M+1.
- Writes to register 0 are permitted (no hardwired zero).
- Forwarding (combinational from state registers):
  - fwd_valid=1 only in COMMIT with regwr=1.
  - fwd_valid=0 in WAIT_MEM; upstream must stall on a matching address (hazard detection is not in this block).
- in_src=3: behaves exactly as ALU.
- Throughput: one non-load per cycle sustained.

Decomposition:
- Shared package: constants SRC_ALU=2'd0, SRC_MEM=2'd1, SRC_LINK=2'd2; state encoding IDLE/WAIT_MEM/COMMIT; DATA_W/ADDR_W defaults shared with the register file.
- Sub-module wb_timeout_counter: clear, enable, terminal-count output; width = clog2(MEM_WAIT_MAX+1). Everything else stays flat in the top module.

Test Plan:
- Reset then ALU op (in_src=0, in_wraddr=3, in_alu=16'h1234, regwr=1) -> regWren=1 for exactly one cycle after accept, wraddr=3, wrdata=16'h1234; fwd_valid=1 that cycle.
- Load (in_src=1, wraddr=5); mem_ready after 4 cycles with mem_rdata=16'hBEEF -> in_ready=0 for 4 cycles, then regWren pulse with wrdata=16'hBEEF, mem_err=0.
- Load with mem_ready held 0 -> after MEM_WAIT_MAX (15) cycles: mem_err=1, no regWren, returns to IDLE. Repeat with mem_ready=1 exactly on cycle 15 -> write occurs, mem_err stays 0.
- Three back-to-back ALU ops (r1=1, r2=2, r7=16'hFFFF) on consecutive cycles -> three consecutive regWren pulses with matching addr/data; in_ready stays 1.
- Link op (in_src=2, in_link=16'h0042, wraddr=7) and regwr=0 op -> first writes 16'h0042 to r7; second produces no regWren and fwd_valid=0.
- Assert reset asynchronously mid-WAIT_MEM -> all outputs zero immediately; a later mem_ready causes no write.
